// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and width defaults for the data memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic {A_PRIO, B_FORCED} arb_state_t;
    typedef enum logic {PORT_A, PORT_B} port_id_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: bounds how long port B can lose to port A before B is forced
module arb_starve_cnt import dmem_arb_pkg::*; #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic b_req,
    input  logic a_acc,
    input  logic b_acc,
    output logic force_b
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    arb_state_t arb_st, st_nxt;
    logic [3:0] starve_cnt, cnt_nxt;
    // next count and priority state; forcing happens on the edge the count reaches the limit
    always_comb begin
        cnt_nxt = (b_acc || !b_req) ? 4'd0 : (a_acc && starve_cnt != 4'hf) ? starve_cnt + 4'd1 : starve_cnt;
        st_nxt  = b_acc ? A_PRIO : (cnt_nxt == LIMIT) ? B_FORCED : arb_st;
    end
    // state and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            arb_st     <= A_PRIO;
            starve_cnt <= 4'd0;
        end else begin
            arb_st     <= st_nxt;
            starve_cnt <= cnt_nxt;
        end
    end
    assign force_b = (arb_st == B_FORCED);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the MEM stage (A) and a secondary master (B)
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int          ADDR_W       = ADDR_W_DEF,
    parameter int          DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic     force_b, acc, win_we, rd_pend;
    port_id_t owner;

    arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clock   (clock),
        .reset_n (reset_n),
        .b_req   (b_req),
        .a_acc   (a_gnt),
        .b_acc   (b_gnt),
        .force_b (force_b)
    );

    // grant: A wins conflicts unless B has been starved; nothing is granted while in reset
    always_comb begin
        a_gnt  = reset_n & a_req & (~b_req | ~force_b);
        b_gnt  = reset_n & b_req & (~a_req | force_b);
        acc    = a_gnt | b_gnt;
        win_we = b_gnt ? b_we : a_we;
    end

    // command stage: the winner's access is presented to memory for one cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= PORT_A;
            rd_pend   <= 1'b0;
        end else begin
            mem_read  <= acc & ~win_we;
            mem_write <= acc & win_we;
            rd_pend   <= acc & ~win_we;
            if (acc) begin
                owner     <= b_gnt ? PORT_B : PORT_A;
                mem_addr  <= b_gnt ? b_addr : a_addr;
                mem_wdata <= b_gnt ? b_wdata : a_wdata;
            end
        end
    end

    // response stage: capture falling-edge read data and return it to the issuing port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= rd_pend && owner == PORT_A;
            b_rvalid <= rd_pend && owner == PORT_B;
            if (rd_pend && owner == PORT_A) a_rdata <= mem_rdata;
            if (rd_pend && owner == PORT_B) b_rdata <= mem_rdata;
        end
    end
endmodule
